// File: rtl/text_overlay_engine_pkg.sv
// Shared types and constants for the character-cell text overlay.
// Cell word layout is {attr[6:0], char[6:0]} with attr = {blink, fg[2:0], bg[2:0]}.
package text_overlay_engine_pkg;

  localparam int CHAR_W      = 7;
  localparam int ATTR_W      = 7;
  localparam int WORD_W      = ATTR_W + CHAR_W;
  localparam int ATTR_BLINK  = 6;
  localparam int ATTR_FG_LSB = 3;
  localparam int ATTR_BG_LSB = 0;

  localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h20;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ovl_state_t;

  typedef struct packed {
    logic [ATTR_W-1:0] attr;
    logic [CHAR_W-1:0] chr;
  } cell_t;

  // 8-entry 4:4:4 palette; index 0 doubles as "transparent" for backgrounds.
  function automatic logic [11:0] pal(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'h000;
      3'd1:    return 12'hF00;
      3'd2:    return 12'h0F0;
      3'd3:    return 12'h007;
      3'd4:    return 12'hFF0;
      3'd5:    return 12'h0FF;
      3'd6:    return 12'hF0F;
      default: return 12'hFFF;
    endcase
  endfunction

endpackage

// File: rtl/ascii_rom.sv
// Glyph ROM, 8x16 cells addressed by {char[6:0], line[3:0]}, registered output.
// Bit 7 of each row is the leftmost pixel. Undefined codes render blank.
module ascii_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  always_ff @(posedge clk) begin
    case (addr)
      // 'A'
      11'h412: data <= 8'h10;
      11'h413: data <= 8'h38;
      11'h414: data <= 8'h6C;
      11'h415: data <= 8'hC6;
      11'h416: data <= 8'hC6;
      11'h417: data <= 8'hFE;
      11'h418: data <= 8'hC6;
      11'h419: data <= 8'hC6;
      11'h41A: data <= 8'hC6;
      11'h41B: data <= 8'hC6;
      // 'B'
      11'h422: data <= 8'hFC;
      11'h423: data <= 8'h66;
      11'h424: data <= 8'h66;
      11'h425: data <= 8'h66;
      11'h426: data <= 8'h7C;
      11'h427: data <= 8'h66;
      11'h428: data <= 8'h66;
      11'h429: data <= 8'h66;
      11'h42A: data <= 8'h66;
      11'h42B: data <= 8'hFC;
      default: data <= 8'h00;
    endcase
  end

endmodule

// File: rtl/text_overlay_engine_tile_ram.sv
// Simple dual-port tile RAM: one write port, one registered read port.
// A same-address write and read in one clock returns the old word.
module text_overlay_engine_tile_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_overlay_engine.sv
// COLS x ROWS character-cell overlay with per-cell colour, blink, integer scaling
// and a hardware screen clear. Pixel path latency is 3 clocks from x/y to text_on/text_rgb.
module text_overlay_engine
  import text_overlay_engine_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 4,
  parameter int ORG_X      = 256,
  parameter int ORG_Y      = 128,
  parameter int SCALE_LOG2 = 0,
  parameter int BLINK_FR   = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [6:0]  wr_char,
  input  logic [6:0]  wr_attr,
  input  logic        clr_req,
  output logic        busy,
  output logic        text_on,
  output logic [11:0] text_rgb,
  output ovl_state_t  dbg_state
);

  // Write handshake: a transfer happens on a clock where wr_valid && wr_ready;
  // wr_ready is high exactly while idle, and out-of-range targets are accepted but dropped.

  localparam int NCELL = COLS * ROWS;
  localparam int AW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int RGN_W = COLS * (8 << SCALE_LOG2);
  localparam int RGN_H = ROWS * (16 << SCALE_LOG2);
  localparam int BW    = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  ovl_state_t    state;
  logic [AW-1:0] clr_addr;

  assign dbg_state = state;

  // Address arithmetic is done modulo 2^AW; any in-range cell index fits exactly.
  logic          wr_fire, wr_hit;
  logic [AW-1:0] wr_addr;

  assign wr_fire = wr_valid && wr_ready;
  assign wr_hit  = wr_fire && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
  assign wr_addr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Held in CLEAR so the walk starts on the first clock after release.
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_req) begin
            clr_addr <= '0;
          end else if (clr_addr == AW'(NCELL - 1)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  cell_t         ram_wdata;

  always_comb begin
    ram_we    = wr_hit;
    ram_waddr = wr_addr;
    ram_wdata = cell_t'({wr_attr, wr_char});
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = cell_t'({7'd0, CHAR_SPACE});
    end
  end

  // S0: region test and cell / glyph coordinates.
  logic [10:0]   dx, dy;
  logic          s0_in;
  logic [9:0]    s0_col, s0_row;
  logic [AW-1:0] s0_raddr;
  logic [2:0]    s0_bit;
  logic [3:0]    s0_line;

  assign dx      = {1'b0, x} - 11'(ORG_X);
  assign dy      = {1'b0, y} - 11'(ORG_Y);
  assign s0_in   = !dx[10] && ({2'b00, dx} < 13'(RGN_W)) &&
                   !dy[10] && ({2'b00, dy} < 13'(RGN_H));
  assign s0_col  = dx[9:0] >> (3 + SCALE_LOG2);
  assign s0_row  = dy[9:0] >> (4 + SCALE_LOG2);
  assign s0_raddr = s0_in ? (AW'(s0_row) * AW'(COLS) + AW'(s0_col)) : '0;
  assign s0_bit  = dx[SCALE_LOG2 +: 3];
  assign s0_line = dy[SCALE_LOG2 +: 4];

  cell_t rd_cell;

  text_overlay_engine_tile_ram #(
    .DEPTH (NCELL),
    .AW    (AW),
    .DW    (WORD_W)
  ) u_tile_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s0_raddr),
    .rdata (rd_cell)
  );

  // S1: tile word available; carry pixel context alongside.
  logic       s1_in;
  logic [2:0] s1_bit;
  logic [3:0] s1_line;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_in   <= 1'b0;
      s1_bit  <= '0;
      s1_line <= '0;
    end else begin
      s1_in   <= s0_in;
      s1_bit  <= s0_bit;
      s1_line <= s0_line;
    end
  end

  logic [7:0] rom_data;

  ascii_rom u_ascii_rom (
    .clk  (clk),
    .addr ({rd_cell.chr, s1_line}),
    .data (rom_data)
  );

  // S2: glyph row available.
  logic              s2_in;
  logic [2:0]        s2_bit;
  logic [ATTR_W-1:0] s2_attr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_in   <= 1'b0;
      s2_bit  <= '0;
      s2_attr <= '0;
    end else begin
      s2_in   <= s1_in;
      s2_bit  <= s1_bit;
      s2_attr <= rd_cell.attr;
    end
  end

  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FR - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // S3: pixel colour. Glyph rows are MSB-leftmost, hence the inverted bit index.
  logic       fg_pix;
  logic [2:0] fg_idx, bg_idx;

  assign fg_pix = rom_data[~s2_bit] && !(s2_attr[ATTR_BLINK] && phase);
  assign fg_idx = s2_attr[ATTR_FG_LSB +: 3];
  assign bg_idx = s2_attr[ATTR_BG_LSB +: 3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      text_on  <= 1'b0;
      text_rgb <= '0;
    end else if (!s2_in) begin
      text_on  <= 1'b0;
      text_rgb <= '0;
    end else begin
      text_on  <= fg_pix || (bg_idx != 3'd0);
      text_rgb <= fg_pix ? pal(fg_idx) : pal(bg_idx);
    end
  end

endmodule

// File: tb/tb_text_overlay_engine.sv
// Bench for text_overlay_engine: two instances (scale 1x and 2x) share all inputs;
// pixel expectations are queued at issue time and popped by a monitor 3 clocks later.
module tb_text_overlay_engine;
  import text_overlay_engine_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        frame_tick = 1'b0;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [6:0]  wr_char = '0, wr_attr = '0;
  logic        clr_req = 1'b0;

  logic        wr_ready0, busy0, text_on0, wr_ready1, busy1, text_on1;
  logic [11:0] text_rgb0, text_rgb1;
  ovl_state_t  st0, st1;

  always #5 clk = ~clk;

  text_overlay_engine #(.COLS(16), .ROWS(4), .ORG_X(256), .ORG_Y(128),
                        .SCALE_LOG2(0), .BLINK_FR(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .wr_attr(wr_attr), .clr_req(clr_req), .busy(busy0),
    .text_on(text_on0), .text_rgb(text_rgb0), .dbg_state(st0));

  text_overlay_engine #(.COLS(16), .ROWS(4), .ORG_X(256), .ORG_Y(128),
                        .SCALE_LOG2(1), .BLINK_FR(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .wr_attr(wr_attr), .clr_req(clr_req), .busy(busy1),
    .text_on(text_on1), .text_rgb(text_rgb1), .dbg_state(st1));

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q0[$], exp_q1[$];
  logic [12:0] e0, e1;
  logic [13:0] cells[64];
  int   blink_cnt = 0;
  logic phase = 1'b0;
  logic pix_vld = 1'b0;
  logic [2:0] v_sr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] tb_pal(input logic [2:0] i);
    logic [11:0] t [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h007,
                           12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};
    return t[i];
  endfunction

  function automatic logic [7:0] font_row(input logic [6:0] ch, input int ln);
    logic [7:0] a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                           8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    if (ch == 7'h41) return a[ln];
    return 8'h00;
  endfunction

  // Reference pixel: {text_on, text_rgb} for scale s at (px, py).
  function automatic logic [12:0] model(input int s, input int px, input int py);
    int dx, dy, col, row, b, ln;
    logic [13:0] w;
    logic [7:0]  g;
    logic        fg, on;
    logic [2:0]  fgi, bgi;
    dx = px - 256;
    dy = py - 128;
    if (dx < 0 || dy < 0 || dx >= 16 * (8 << s) || dy >= 4 * (16 << s)) return 13'd0;
    col = dx >> (3 + s);
    row = dy >> (4 + s);
    b   = (dx >> s) % 8;
    ln  = (dy >> s) % 16;
    w   = cells[row * 16 + col];
    g   = font_row(w[6:0], ln);
    fg  = g[7 - b] && !(w[13] && phase);
    fgi = w[12:10];
    bgi = w[9:7];
    on  = fg || (bgi != 3'd0);
    return {on, fg ? tb_pal(fgi) : tb_pal(bgi)};
  endfunction

  always @(posedge clk) v_sr <= {v_sr[1:0], pix_vld};

  always @(negedge clk) begin
    if (v_sr[2]) begin
      if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_queue: output with no expectation queued at %0t", $time);
      end else begin
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check("pix_s0", {19'd0, text_on0, text_rgb0}, {19'd0, e0});
        check("pix_s1", {19'd0, text_on1, text_rgb1}, {19'd0, e1});
      end
    end
  end

  task automatic scan(input int x0, input int y0, input int w, input int h, input int step);
    for (int j = 0; j < h; j += step) begin
      for (int i = 0; i < w; i += step) begin
        @(posedge clk); #1;
        x = 10'(x0 + i);
        y = 10'(y0 + j);
        pix_vld = 1'b1;
        exp_q0.push_back(model(0, x0 + i, y0 + j));
        exp_q1.push_back(model(1, x0 + i, y0 + j));
      end
    end
    @(posedge clk); #1 pix_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int col, input int row, input logic [6:0] ch, input logic [6:0] at);
    int n;
    n = 0;
    @(posedge clk); #1;
    wr_col = 6'(col); wr_row = 5'(row); wr_char = ch; wr_attr = at; wr_valid = 1'b1;
    @(negedge clk);
    while (!wr_ready0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("write_handshake", {31'd0, wr_ready0}, 32'd1);
    @(posedge clk); #1 wr_valid = 1'b0;
    if (col < 16 && row < 4) cells[row * 16 + col] = {at, ch};
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    if (blink_cnt == 1) begin
      blink_cnt = 0;
      phase = ~phase;
    end else begin
      blink_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    for (int i = 0; i < 64; i++) cells[i] = {7'd0, 7'h20};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready0}, 32'd0);
    check("rst_text_on", {31'd0, text_on0}, 32'd0);
    check("rst_text_rgb", {20'd0, text_rgb1}, 32'd0);
    check("rst_busy_s1", {31'd0, busy1}, 32'd1);

    @(posedge clk); #1 reset_n = 1'b1;
    n = 0;
    bad = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy0) break;
      if (wr_ready0) bad++;
      n++;
    end
    check("clear_busy_len", n, 32'd64);
    check("clear_ready_low", bad, 32'd0);
    check("idle_ready", {31'd0, wr_ready0}, 32'd1);
    check("idle_state", {31'd0, st0}, {31'd0, ST_IDLE});
    check("idle_state_s1", {31'd0, st1}, {31'd0, ST_IDLE});

    scan(248, 120, 144, 80, 4);

    do_write(0, 0, 7'h41, 7'h08);
    scan(252, 124, 24, 40, 1);

    do_write(20, 0, 7'h41, 7'h3F);
    do_write(2, 6, 7'h41, 7'h3F);
    scan(256, 128, 128, 64, 1);

    do_write(1, 0, 7'h41, 7'h53);
    for (int f = 0; f < 8; f++) begin
      scan(256, 128, 32, 32, 1);
      tick();
    end

    @(posedge clk); #1 clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    wr_col = 6'd3; wr_row = 5'd2; wr_char = 7'h41; wr_attr = 7'h08; wr_valid = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (wr_ready0) break;
      n++;
    end
    check("clr_ready_low_len", n, 32'd64);
    check("clr_busy_done", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1 wr_valid = 1'b0;
    for (int i = 0; i < 64; i++) cells[i] = {7'd0, 7'h20};
    cells[2 * 16 + 3] = {7'h08, 7'h41};
    scan(256, 128, 128, 64, 1);
    scan(296, 188, 32, 40, 1);

    check("queues_drained", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
